// File: rtl/note_sequencer.sv
// note_sequencer: walks a song ROM of {pitch, duration} words and emits timed
// note events. Each note plays for duration * tick_div clock cycles, with a
// two-cycle FETCH/LATCH gap between notes to cover the synchronous ROM latency.
module note_sequencer #(
    parameter  int unsigned ADDR_W = 8,
    localparam int unsigned TICK_W = 27
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic [ADDR_W-1:0] i_song_len,
    input  logic [TICK_W-1:0] i_tick_div,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [11:0]       i_rom_data,
    output logic [5:0]        o_note_pitch,
    output logic              o_note_valid,
    output logic              o_note_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned PITCH_W = 6;
    localparam int unsigned DUR_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_song_len;
    logic [TICK_W-1:0]   r_tick_div;
    logic [ADDR_W-1:0]   r_index;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [PITCH_W-1:0]  r_note_pitch;
    logic                r_note_valid;
    logic                r_note_start;
    logic                r_busy;
    logic                r_done;

    logic [PITCH_W-1:0]  w_rom_pitch;
    logic [DUR_W-1:0]    w_rom_dur;
    logic [TICK_W-1:0]   w_tick_div_eff;
    logic                w_tick_wrap;
    logic [ADDR_W-1:0]   w_index_nxt;
    logic                w_more_notes;

    // ROM word fields
    assign w_rom_pitch    = i_rom_data[11:6];
    assign w_rom_dur      = i_rom_data[5:0];

    // A zero divider would never wrap, so it behaves as a divide-by-one
    assign w_tick_div_eff = (i_tick_div == '0) ? TICK_W'(1) : i_tick_div;

    // Tick counter reaches its last value this cycle
    assign w_tick_wrap    = (r_tick_cnt == (r_tick_div - TICK_W'(1)));

    // Next index; song_len never exceeds 2^ADDR_W-1 so this cannot wrap while playing
    assign w_index_nxt    = r_index + ADDR_W'(1);
    assign w_more_notes   = (w_index_nxt < r_song_len);

    // Playback FSM with registered outputs; reset wins over every other input
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_song_len   <= '0;
            r_tick_div   <= '0;
            r_index      <= '0;
            r_tick_cnt   <= '0;
            r_dur_cnt    <= '0;
            r_rom_addr   <= '0;
            r_note_pitch <= '0;
            r_note_valid <= 1'b0;
            r_note_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_note_start <= 1'b0;
            r_done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_song_len <= i_song_len;
                        r_tick_div <= w_tick_div_eff;
                        r_index    <= '0;
                        r_rom_addr <= '0;
                        r_tick_cnt <= '0;
                        r_dur_cnt  <= '0;
                        r_busy     <= 1'b1;
                        if (i_song_len == '0) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_note_valid <= 1'b0;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    // ROM is reading r_rom_addr this cycle
                    r_state <= S_LATCH;
                end

                S_LATCH: begin
                    if (w_rom_dur == '0) begin
                        // Zero duration marks end of song
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_note_valid <= 1'b0;
                    end else begin
                        r_state      <= S_PLAY;
                        r_note_pitch <= w_rom_pitch;
                        r_dur_cnt    <= w_rom_dur;
                        r_tick_cnt   <= '0;
                        r_note_start <= 1'b1;
                        r_note_valid <= 1'b1;
                    end
                end

                S_PLAY: begin
                    if (!i_pause) begin
                        if (w_tick_wrap) begin
                            r_tick_cnt <= '0;
                            r_dur_cnt  <= r_dur_cnt - DUR_W'(1);
                            if (r_dur_cnt == DUR_W'(1)) begin
                                if (w_more_notes) begin
                                    r_index    <= w_index_nxt;
                                    r_rom_addr <= w_index_nxt;
                                    r_state    <= S_FETCH;
                                end else begin
                                    r_state      <= S_DONE;
                                    r_done       <= 1'b1;
                                    r_note_valid <= 1'b0;
                                end
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_note_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_note_pitch = r_note_pitch;
    assign o_note_valid = r_note_valid;
    assign o_note_start = r_note_start;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a timeline model predicts, per cycle after start,
// the note_start/done/busy/note_valid/pitch/rom_addr values from the song
// rules, and every cycle of each song is compared against it.
module tb_note_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int          MAXC   = 4096;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_start;
    logic              i_pause;
    logic [ADDR_W-1:0] i_song_len;
    logic [26:0]       i_tick_div;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [11:0]       rom_data;
    logic [5:0]        o_note_pitch;
    logic              o_note_valid;
    logic              o_note_start;
    logic              o_busy;
    logic              o_done;

    logic [11:0]       rom [0:255];

    int checks = 0;
    int errors = 0;
    int cur_cyc = 0;

    bit                exp_start [MAXC];
    logic [5:0]        exp_pitch [MAXC];
    logic [ADDR_W-1:0] exp_addr  [MAXC];
    bit                pause_pat [MAXC];
    int                exp_done;
    int                exp_first;

    note_sequencer #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_pause      (i_pause),
        .i_song_len   (i_song_len),
        .i_tick_div   (i_tick_div),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (rom_data),
        .o_note_pitch (o_note_pitch),
        .o_note_valid (o_note_valid),
        .o_note_start (o_note_start),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: data valid one cycle after the address
    always @(posedge clk) rom_data <= rom[o_rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_cyc, obs, exp);
        end
    endtask

    task automatic set_pause_none();
        for (int k = 0; k < MAXC; k++) pause_pat[k] = 1'b0;
    endtask

    task automatic set_pause_rand();
        for (int k = 0; k < MAXC; k++) pause_pat[k] = ($urandom_range(0, 3) == 0);
    endtask

    // Timeline model. Cycle 0 is the first cycle after start is taken.
    // A note's fetch cycle is t, it sounds from t+2, and it ends once
    // duration*max(tick_div,1) unpaused cycles have elapsed.
    task automatic build_model(input int len, input int div);
        int divv, t, c, cnt, need, d;
        for (int k = 0; k < MAXC; k++) begin
            exp_start[k] = 1'b0;
            exp_pitch[k] = '0;
            exp_addr[k]  = '0;
        end
        divv      = (div == 0) ? 1 : div;
        t         = 0;
        exp_first = -1;
        exp_done  = 0;
        for (int i = 0; i < len; i++) begin
            d = int'(rom[i][5:0]);
            if (d == 0) begin
                exp_done = t + 2;
                return;
            end
            need         = d * divv;
            c            = t + 2;
            exp_start[c] = 1'b1;
            exp_pitch[c] = rom[i][11:6];
            exp_addr[c]  = ADDR_W'(i);
            if (exp_first < 0) exp_first = c;
            cnt = 0;
            while (c < MAXC - 4) begin
                if (!pause_pat[c]) cnt++;
                if (cnt == need) break;
                c++;
            end
            t = c + 1;
        end
        exp_done = t;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rom_addr",   32'(o_rom_addr),   32'(0));
        chk("rst_note_pitch", 32'(o_note_pitch), 32'(0));
        chk("rst_note_valid", 32'(o_note_valid), 32'(0));
        chk("rst_note_start", 32'(o_note_start), 32'(0));
        chk("rst_busy",       32'(o_busy),       32'(0));
        chk("rst_done",       32'(o_done),       32'(0));
    endtask

    // Start one song and compare every cycle; rst_at >= 0 aborts with reset
    task automatic run_song(input int len, input int div, input int rst_at);
        logic [5:0] cur_pitch;
        int         last;
        bit         valid_exp;
        build_model(len, div);
        last       = (rst_at >= 0) ? rst_at : exp_done + 1;
        i_song_len = ADDR_W'(len);
        i_tick_div = 27'(div);
        i_start    = 1'b1;
        i_pause    = 1'($urandom_range(0, 1));
        cur_pitch  = '0;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            cur_cyc   = c;
            valid_exp = (exp_first >= 0) && (c >= exp_first) && (c < exp_done);
            if (exp_start[c]) cur_pitch = exp_pitch[c];
            chk("note_start", 32'(o_note_start), 32'(exp_start[c]));
            chk("done",       32'(o_done),       32'(c == exp_done));
            chk("busy",       32'(o_busy),       32'(c <= exp_done));
            chk("note_valid", 32'(o_note_valid), 32'(valid_exp));
            if (exp_start[c]) chk("rom_addr", 32'(o_rom_addr), 32'(exp_addr[c]));
            if (valid_exp)    chk("note_pitch", 32'(o_note_pitch), 32'(cur_pitch));
            i_pause    = pause_pat[c];
            i_start    = (c <= exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_song_len = ADDR_W'($urandom);
            i_tick_div = 27'($urandom);
            if (c == rst_at) begin
                i_reset = 1'b1;
                i_start = 1'b1;
                i_pause = 1'b1;
            end
        end
        if (rst_at >= 0) begin
            @(posedge clk);
            #1;
            cur_cyc = last + 1;
            chk_reset_outputs();
            i_reset = 1'b0;
            i_start = 1'b0;
            i_pause = 1'b0;
        end
    endtask

    initial begin
        int len, div;
        i_reset    = 1'b1;
        i_start    = 1'b1;
        i_pause    = 1'b1;
        i_song_len = '0;
        i_tick_div = '0;
        for (int k = 0; k < 256; k++) rom[k] = 12'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        i_reset = 1'b0;
        i_start = 1'b0;
        i_pause = 1'b0;

        // Two notes, pitch 5 for 30 cycles then pitch 9 for 15 cycles
        rom[0] = {6'd5, 6'd2};
        rom[1] = {6'd9, 6'd1};
        set_pause_none();
        run_song(2, 15, -1);

        // Zero duration at index 1 ends the song early
        rom[0] = {6'd12, 6'd3};
        rom[1] = {6'd20, 6'd0};
        rom[2] = {6'd7,  6'd2};
        run_song(3, 5, -1);

        // tick_div of zero behaves as one
        rom[0] = {6'd40, 6'd3};
        run_song(1, 0, -1);

        // Seven paused cycles mid-note stretch a 10-cycle note to 17
        rom[0] = {6'd17, 6'd2};
        set_pause_none();
        for (int k = 5; k <= 11; k++) pause_pat[k] = 1'b1;
        run_song(1, 5, -1);

        // Reset during the second note, then restart from index 0
        rom[0] = {6'd3,  6'd1};
        rom[1] = {6'd44, 6'd2};
        set_pause_none();
        run_song(2, 3, 8);
        run_song(2, 3, -1);

        // Empty song, with random start pulses while busy
        run_song(0, 4, -1);
        run_song(0, 0, -1);

        // Longest song plays every entry without index wrap
        for (int k = 0; k < 256; k++) rom[k] = {6'($urandom), 6'd1};
        set_pause_none();
        run_song(255, 1, -1);

        // Random songs with random pauses and random input churn
        repeat (40) begin
            len = int'($urandom_range(0, 6));
            div = int'($urandom_range(0, 5));
            for (int k = 0; k < 8; k++)
                rom[k] = {6'($urandom),
                          ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 6))};
            set_pause_rand();
            run_song(len, div, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: song ROM address width and note index width.
REQ-002 clk  input  1: single system clock; all logic SHALL be rising-edge clocked.
REQ-003 reset  input  1: synchronous, active-high reset.
REQ-004 start  input  1: level; sampled only in IDLE; begins playback at index 0.
REQ-005 pause  input  1: level; freezes tick and duration counting while high.
REQ-006 song_len  input  ADDR_W: number of ROM entries to play; sampled at start.
REQ-007 tick_div  input  27: clk cycles per duration tick; sampled at start.
REQ-008 rom_addr  output  ADDR_W: song ROM address, registered.
REQ-009 rom_data  input  12: ROM word, valid 1 cycle after rom_addr; [11:6] pitch, [5:0] duration in ticks.
REQ-010 note_pitch  output  6: pitch of the current note.
REQ-011 note_valid  output  1: high from first note_start until playback ends.
REQ-012 note_start  output  1: one-cycle pulse per new note.
REQ-013 busy  output  1: high in every state except IDLE.
REQ-014 done  output  1: one-cycle pulse at end of playback.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, LATCH, PLAY and DONE.
REQ-016 IDLE, start=1: capture song_len and tick_div, set index=0 and rom_addr=0, go to FETCH; if song_len=0, go to DONE instead.
REQ-017 FETCH SHALL last exactly one cycle, covering ROM latency, then go to LATCH.
REQ-018 LATCH, duration=0: treat as end-of-song and go to DONE.
REQ-019 LATCH, duration!=0: load note_pitch, load the duration counter with duration, clear the tick counter, go to PLAY; note_start and note_valid SHALL be 1 in the first PLAY cycle.
REQ-020 Tick counter SHALL count 0..tick_div-1 and wrap to 0; a captured tick_div of 0 SHALL be treated as 1.
REQ-021 Each tick wrap SHALL decrement the duration counter.
REQ-022 Tick wrap with duration counter=1, index+1<song_len: increment index, set rom_addr=index+1, go to FETCH.
REQ-023 Tick wrap with duration counter=1, index+1=song_len: go to DONE.
REQ-024 With no pause, PLAY for one note SHALL last exactly duration*tick_div cycles; the inter-note gap (FETCH+LATCH) SHALL be 2 cycles.
REQ-025 During the gap, note_valid SHALL stay 1 and note_pitch SHALL hold the previous value.
REQ-026 pause=1 in PLAY SHALL freeze tick and duration counters; pause in FETCH or LATCH has no effect; the note extends by exactly the number of paused cycles.
REQ-027 DONE SHALL last one cycle: done=1, note_valid cleared; next state IDLE. busy SHALL be 0 from the following cycle.
REQ-028 start while busy SHALL be ignored; changes to song_len or tick_div during playback SHALL have no effect.
REQ-029 Index arithmetic SHALL be ADDR_W-bit unsigned; song_len=2^ADDR_W-1 SHALL play all entries without wrap.
REQ-030 Counters SHALL be wide enough for tick_div up to 2^27-1 and duration up to 63 with no overflow.

Reset
REQ-031 reset=1 SHALL force IDLE from any state, including mid-PLAY, on the next edge, with no done pulse.
REQ-032 Reset values SHALL be: rom_addr=0, note_pitch=0, note_valid=0, note_start=0, busy=0, done=0, index=0, all counters=0.
REQ-033 reset SHALL take priority over start and pause in the same cycle.

Verification
REQ-034 tick_div=15, song_len=2, ROM[0]={5,2}, ROM[1]={9,1}, start one cycle -> note_start at pitch 5, 30 cycles later a 2-cycle gap, note_start at pitch 9, 15 cycles later done pulse; busy then 0.
REQ-035 tick_div=5, song_len=3, ROM[1].duration=0 -> note at index 0 plays 5*dur cycles, then done without a second note_start.
REQ-036 tick_div=0, song_len=1, duration=3 -> note lasts 3 cycles, then done.
REQ-037 pause high for 7 cycles mid-note with tick_div=5, duration=2 -> note lasts 17 cycles.
REQ-038 reset asserted mid-PLAY -> next cycle all outputs at reset values, no done; start 1 cycle later -> rom_addr=0 and playback restarts from index 0.
REQ-039 song_len=0 with start -> busy for one cycle, done pulse, note_start never asserted; start pulsed while busy -> no restart.
